// File: rtl/mc_ctrl.sv
// Multicycle IF/ID/EX/MEM/WB sequencer for the MIPS-subset CPU.
// Drives datapath enables, stalls on MemRdy and halts with a sticky Fault.
module mc_ctrl #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        Zero,
  input  logic        MemRdy,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        EXTOp,
  output logic [2:0]  ALUOp,
  output logic [1:0]  NPCOp,
  output logic [1:0]  ALUSrcA,
  output logic        ALUSrcB,
  output logic        GPRSel,
  output logic        WDSel,
  output logic [2:0]  State,
  output logic        Fault,
  output logic [31:0] InstrCnt
);

  // state | meaning
  // IF    | fetch, wait for MemRdy     ID  | decode, j completes
  // EX    | ALU, beq completes         MEM | lw/sw access
  // WB    | register write, PC update  HALT| fault, absorbing until reset
  typedef enum logic [2:0] {
    ST_IF   = 3'd0,
    ST_ID   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_WB   = 3'd4,
    ST_HALT = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  localparam logic [2:0] ALU_NOP  = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_OR   = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_SLL  = 3'b111;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JMP  = 2'b10;

  localparam logic [7:0] TIMEOUT  = 8'(MEM_TIMEOUT);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  logic        legal, is_lw, is_sw, is_beq, is_j;
  logic [2:0]  dec_aluop;
  logic [1:0]  dec_srca;
  logic        dec_extop, dec_srcb, dec_gpr, dec_wd;

  logic        mem_read, mem_write, ir_write, pc_write, reg_write, dec_en;
  logic [1:0]  npc_op;

  always_comb begin
    legal     = 1'b1;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    is_beq    = 1'b0;
    is_j      = 1'b0;
    dec_aluop = ALU_NOP;
    dec_srca  = 2'b00;
    dec_extop = 1'b0;
    dec_srcb  = 1'b0;
    dec_gpr   = 1'b0;
    dec_wd    = 1'b0;
    case (Op)
      OP_RTYPE: begin
        case (Funct)
          FN_ADD, FN_ADDU: dec_aluop = ALU_ADD;
          FN_SUB, FN_SUBU: dec_aluop = ALU_SUB;
          FN_AND:          dec_aluop = ALU_AND;
          FN_OR:           dec_aluop = ALU_OR;
          FN_SLT:          dec_aluop = ALU_SLT;
          FN_SLTU:         dec_aluop = ALU_SLTU;
          FN_SLL: begin
            dec_aluop = ALU_SLL;
            dec_srca  = 2'b01;
          end
          default:         legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        dec_aluop = ALU_ADD;
        dec_extop = 1'b1;
        dec_srcb  = 1'b1;
        dec_gpr   = 1'b1;
      end
      OP_ORI: begin
        dec_aluop = ALU_OR;
        dec_srcb  = 1'b1;
        dec_gpr   = 1'b1;
      end
      OP_LUI: begin
        dec_aluop = ALU_ADD;
        dec_srca  = 2'b10;
        dec_gpr   = 1'b1;
      end
      OP_LW: begin
        is_lw     = 1'b1;
        dec_aluop = ALU_ADD;
        dec_extop = 1'b1;
        dec_srcb  = 1'b1;
        dec_gpr   = 1'b1;
        dec_wd    = 1'b1;
      end
      OP_SW: begin
        is_sw     = 1'b1;
        dec_aluop = ALU_ADD;
        dec_extop = 1'b1;
        dec_srcb  = 1'b1;
      end
      OP_BEQ: begin
        is_beq    = 1'b1;
        dec_aluop = ALU_SUB;
      end
      OP_J:    is_j  = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  // Wait counter is nonzero only while stalled, so every exit leaves it at 0.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = 8'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    dec_en     = 1'b0;
    npc_op     = NPC_PC4;
    case (state_q)
      ST_IF: begin
        mem_read = 1'b1;
        if (MemRdy) begin
          ir_write = 1'b1;
          state_d  = ST_ID;
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ID: begin
        dec_en = 1'b1;
        if (!legal) begin
          state_d = ST_HALT;
        end else if (is_j) begin
          pc_write = 1'b1;
          npc_op   = NPC_JMP;
          state_d  = ST_IF;
        end else begin
          state_d = ST_EX;
        end
      end
      ST_EX: begin
        dec_en = 1'b1;
        if (is_beq) begin
          pc_write = 1'b1;
          npc_op   = Zero ? NPC_BR : NPC_PC4;
          state_d  = ST_IF;
        end else if (is_lw || is_sw) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        dec_en    = 1'b1;
        mem_write = is_sw;
        mem_read  = !is_sw;
        if (MemRdy) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_d  = ST_IF;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_cnt_q == TIMEOUT) begin
          state_d = ST_HALT;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_WB: begin
        dec_en    = 1'b1;
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = ST_IF;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  always_comb begin
    fault_d     = fault_q | (state_d == ST_HALT);
    instr_cnt_d = instr_cnt_q + {31'd0, pc_write};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IF;
      wait_cnt_q  <= 8'd0;
      fault_q     <= 1'b0;
      instr_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      fault_q     <= fault_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  // Combinational outputs are forced low while rstn is asserted.
  assign MemRead  = rstn & mem_read;
  assign MemWrite = rstn & mem_write;
  assign IRWrite  = rstn & ir_write;
  assign PCWrite  = rstn & pc_write;
  assign RegWrite = rstn & reg_write;
  assign NPCOp    = rstn ? npc_op : NPC_PC4;
  assign EXTOp    = rstn & dec_en & dec_extop;
  assign ALUOp    = (rstn && dec_en) ? dec_aluop : ALU_NOP;
  assign ALUSrcA  = (rstn && dec_en) ? dec_srca : 2'b00;
  assign ALUSrcB  = rstn & dec_en & dec_srcb;
  assign GPRSel   = rstn & dec_en & dec_gpr;
  assign WDSel    = rstn & dec_en & dec_wd;

  assign State    = state_q;
  assign Fault    = fault_q;
  assign InstrCnt = instr_cnt_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: table-driven instruction model with random memory stalls,
// plus timeout, illegal-opcode and asynchronous-reset scenarios.
`timescale 1ns/1ps
module tb_mc_ctrl;
  localparam int TMO   = 15;
  localparam int C_ALU = 0;
  localparam int C_LW  = 1;
  localparam int C_SW  = 2;
  localparam int C_BEQ = 3;
  localparam int C_J   = 4;

  logic        clk, rstn;
  logic [5:0]  Op, Funct;
  logic        Zero, MemRdy;
  logic        MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp;
  logic [2:0]  ALUOp;
  logic [1:0]  NPCOp, ALUSrcA;
  logic        ALUSrcB, GPRSel, WDSel;
  logic [2:0]  State;
  logic        Fault;
  logic [31:0] InstrCnt;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] model_cnt = 32'd0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         cls;
    logic [2:0] alu;
    logic       ext;
    logic [1:0] sa;
    logic       sb;
    logic       gpr;
    logic       wd;
  } instr_t;

  instr_t tbl [16];

  mc_ctrl #(.MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .MemRdy(MemRdy),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .RegWrite(RegWrite), .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .GPRSel(GPRSel), .WDSel(WDSel),
    .State(State), .Fault(Fault), .InstrCnt(InstrCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic init_tbl();
    tbl[0]  = '{6'h00, 6'h20, C_ALU, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'h00, 6'h21, C_ALU, 3'b001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{6'h00, 6'h22, C_ALU, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{6'h00, 6'h23, C_ALU, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{6'h00, 6'h24, C_ALU, 3'b011, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'h00, 6'h25, C_ALU, 3'b100, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{6'h00, 6'h2A, C_ALU, 3'b101, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{6'h00, 6'h2B, C_ALU, 3'b110, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{6'h00, 6'h00, C_ALU, 3'b111, 1'b0, 2'b01, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{6'h08, 6'h00, C_ALU, 3'b001, 1'b1, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{6'h0D, 6'h00, C_ALU, 3'b100, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{6'h0F, 6'h00, C_ALU, 3'b001, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{6'h23, 6'h00, C_LW,  3'b001, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1};
    tbl[13] = '{6'h2B, 6'h00, C_SW,  3'b001, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{6'h04, 6'h00, C_BEQ, 3'b010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{6'h02, 6'h00, C_J,   3'b000, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0};
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rstn   = 1'b0;
    MemRdy = 1'b0;
    @(negedge clk);
    rstn      = 1'b1;
    model_cnt = 32'd0;
  endtask

  // Entered and left on a falling edge with the DUT in IF. MemRdy is held low
  // for wif cycles in IF and wmem cycles in MEM; it is random elsewhere.
  task automatic run_instr(input int idx, input logic z, input int wif, input int wmem);
    instr_t      e;
    int          cyc, waits, mr, mw, irw, pcw, rw, lat;
    logic [2:0]  st, prev_st, alu_ex;
    logic [1:0]  npc_end, npc_exp;
    logic [8:0]  dec_end, dec_exp;
    logic [39:0] cnt_obs, cnt_exp;
    logic        ex_seen, if_bad, done, is_mem;
    e = tbl[idx];
    Op    = e.op;
    Funct = (e.op == 6'h00) ? e.fn : 6'($urandom);
    Zero  = z;
    cyc = 0; waits = 0; mr = 0; mw = 0; irw = 0; pcw = 0; rw = 0;
    prev_st = 3'd7; alu_ex = 3'bxxx; npc_end = 2'b11; dec_end = '1;
    ex_seen = 1'b0; if_bad = 1'b0; done = 1'b0;
    while (!done && cyc < 64) begin
      st = State;
      if (st != prev_st) waits = 0;
      prev_st = st;
      if (st == 3'd0)      MemRdy = (waits >= wif);
      else if (st == 3'd3) MemRdy = (waits >= wmem);
      else                 MemRdy = 1'($urandom);
      #1;
      cyc++;
      if ((st == 3'd0 || st == 3'd3) && !MemRdy) waits++;
      mr  += int'(MemRead);
      mw  += int'(MemWrite);
      irw += int'(IRWrite);
      pcw += int'(PCWrite);
      rw  += int'(RegWrite);
      if (st == 3'd2 && !ex_seen) begin
        alu_ex  = ALUOp;
        ex_seen = 1'b1;
      end
      if (st == 3'd0 && {ALUOp, EXTOp, ALUSrcA, ALUSrcB, GPRSel, WDSel} != 9'd0) if_bad = 1'b1;
      if (PCWrite) begin
        done    = 1'b1;
        npc_end = NPCOp;
        dec_end = {ALUOp, EXTOp, ALUSrcA, ALUSrcB, GPRSel, WDSel};
      end
      @(negedge clk);
    end
    is_mem = (e.cls == C_LW || e.cls == C_SW);
    case (e.cls)
      C_LW:    lat = 5;
      C_BEQ:   lat = 3;
      C_J:     lat = 2;
      default: lat = 4;
    endcase
    lat = lat + wif + (is_mem ? wmem : 0);
    cnt_exp = {8'(1 + wif + ((e.cls == C_LW) ? 1 + wmem : 0)),
               8'((e.cls == C_SW) ? 1 + wmem : 0), 8'd1, 8'd1,
               8'((e.cls == C_ALU || e.cls == C_LW) ? 1 : 0)};
    cnt_obs = {8'(mr), 8'(mw), 8'(irw), 8'(pcw), 8'(rw)};
    npc_exp = (e.cls == C_J) ? 2'b10 : (e.cls == C_BEQ && z) ? 2'b01 : 2'b00;
    dec_exp = {e.alu, e.ext, e.sa, e.sb, e.gpr, e.wd};
    model_cnt = model_cnt + 32'd1;

    n_chk++;
    if (done !== 1'b1) $display("FAIL instr_done op=%h fn=%h: no PCWrite within %0d cycles", Op, Funct, cyc);
    else n_pass++;
    n_chk++;
    if (cyc !== lat) $display("FAIL latency op=%h fn=%h wif=%0d wmem=%0d: got %0d want %0d", Op, Funct, wif, wmem, cyc, lat);
    else n_pass++;
    n_chk++;
    if (cnt_obs !== cnt_exp) $display("FAIL strobe_counts op=%h {rd,wr,ir,pc,rf}: got %h want %h", Op, cnt_obs, cnt_exp);
    else n_pass++;
    n_chk++;
    if (npc_end !== npc_exp) $display("FAIL npcop op=%h zero=%b: got %b want %b", Op, z, npc_end, npc_exp);
    else n_pass++;
    n_chk++;
    if (dec_end !== dec_exp) $display("FAIL decode op=%h fn=%h: got %b want %b", Op, Funct, dec_end, dec_exp);
    else n_pass++;
    if (e.cls != C_J) begin
      n_chk++;
      if (alu_ex !== e.alu) $display("FAIL aluop_ex op=%h fn=%h: got %b want %b", Op, Funct, alu_ex, e.alu);
      else n_pass++;
    end
    n_chk++;
    if (if_bad !== 1'b0) $display("FAIL if_decode_zero op=%h: got %b want 0", Op, if_bad);
    else n_pass++;
    n_chk++;
    if ({State, Fault, InstrCnt} !== {3'd0, 1'b0, model_cnt})
      $display("FAIL retire op=%h: got st=%0d f=%b cnt=%0d want st=0 f=0 cnt=%0d", Op, State, Fault, InstrCnt, model_cnt);
    else n_pass++;
  endtask

  task automatic test_reset();
    rstn = 1'b1; MemRdy = 1'b1; Op = 6'h23; Funct = 6'h20; Zero = 1'b0;
    #2 rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if ({State, Fault, InstrCnt} !== 36'd0)
      $display("FAIL reset_regs: got st=%0d f=%b cnt=%0d want 0/0/0", State, Fault, InstrCnt);
    else n_pass++;
    n_chk++;
    if ({MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel} !== 16'd0)
      $display("FAIL reset_outputs: got rd=%b ir=%b alu=%b want all 0", MemRead, IRWrite, ALUOp);
    else n_pass++;
    @(negedge clk);
    rstn = 1'b1;
    model_cnt = 32'd0;
  endtask

  task automatic test_add();
    run_instr(0, 1'b0, 0, 0);
  endtask

  task automatic test_lw_wait();
    run_instr(12, 1'b0, 0, 3);
  endtask

  task automatic test_beq_j();
    run_instr(14, 1'b1, 0, 0);
    run_instr(14, 1'b0, 0, 0);
    run_instr(15, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int idx, wif, wmem;
      idx  = int'($urandom_range(0, 15));
      wif  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO)) : 0;
      wmem = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO)) : 0;
      run_instr(idx, 1'($urandom), wif, wmem);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    Op = 6'h2B; Funct = 6'($urandom); Zero = 1'b0; n = 0;
    while (State != 3'd3 && n < 10) begin
      MemRdy = 1'b1;
      n++;
      @(negedge clk);
    end
    MemRdy = 1'b0;
    #1;
    n_chk++;
    if ({State, MemWrite} !== {3'd3, 1'b1}) $display("FAIL sw_in_mem: got st=%0d wr=%b want 3/1", State, MemWrite);
    else n_pass++;
    #1 rstn = 1'b0;
    #1;
    n_chk++;
    if ({State, Fault, InstrCnt, MemWrite, MemRead} !== 38'd0)
      $display("FAIL async_reset: got st=%0d cnt=%0d wr=%b rd=%b want 0/0/0/0", State, InstrCnt, MemWrite, MemRead);
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    n_chk++;
    if ({State, MemRead} !== {3'd0, 1'b1}) $display("FAIL refetch: got st=%0d rd=%b want 0/1", State, MemRead);
    else n_pass++;
    apply_reset();
  endtask

  task automatic test_timeout_edge();
    run_instr(12, 1'b0, TMO, TMO);
    run_instr(13, 1'b1, TMO, TMO);
  endtask

  task automatic test_timeout();
    int   n_if;
    logic bad;
    n_if = 0; bad = 1'b0;
    Op = 6'h00; Funct = 6'h20; MemRdy = 1'b0;
    while (State == 3'd0 && n_if < 40) begin
      #1;
      if (MemRead !== 1'b1) bad = 1'b1;
      n_if++;
      @(negedge clk);
    end
    n_chk++;
    if (n_if !== TMO + 1) $display("FAIL timeout_cycles: got %0d want %0d", n_if, TMO + 1);
    else n_pass++;
    n_chk++;
    if ({State, Fault} !== {3'd5, 1'b1}) $display("FAIL timeout_halt: got st=%0d f=%b want 5/1", State, Fault);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      MemRdy = 1'($urandom); Op = 6'($urandom); Funct = 6'($urandom); Zero = 1'($urandom);
      #1;
      if ({MemRead, MemWrite, IRWrite, PCWrite, RegWrite, EXTOp, ALUOp, NPCOp, ALUSrcA, ALUSrcB, GPRSel, WDSel} !== 16'd0
          || State !== 3'd5 || Fault !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    n_chk++;
    if (bad !== 1'b0) $display("FAIL halt_quiet: got %b want 0", bad);
    else n_pass++;
    n_chk++;
    if (InstrCnt !== model_cnt) $display("FAIL timeout_cnt: got %0d want %0d", InstrCnt, model_cnt);
    else n_pass++;
  endtask

  task automatic test_illegal(input logic [5:0] op, input logic [5:0] fn);
    int   cyc;
    logic pcw_seen;
    apply_reset();
    Op = op; Funct = fn; MemRdy = 1'b1; cyc = 0; pcw_seen = 1'b0;
    while (State != 3'd5 && cyc < 10) begin
      #1;
      if (PCWrite) pcw_seen = 1'b1;
      cyc++;
      @(negedge clk);
    end
    n_chk++;
    if (cyc !== 2) $display("FAIL illegal_cycles op=%h fn=%h: got %0d want 2", op, fn, cyc);
    else n_pass++;
    n_chk++;
    if ({Fault, pcw_seen, InstrCnt} !== {1'b1, 1'b0, model_cnt})
      $display("FAIL illegal_state op=%h: got f=%b pcw=%b cnt=%0d want 1/0/%0d", op, Fault, pcw_seen, InstrCnt, model_cnt);
    else n_pass++;
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_add();
    test_lw_wait();
    test_beq_j();
    test_random();
    test_reset_mid();
    test_timeout_edge();
    test_timeout();
    test_illegal(6'h3F, 6'($urandom));
    test_illegal(6'h00, 6'h01);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle sequencing controller for the MIPS-subset CPU. It replaces the single-cycle decoder with a state machine that steps each instruction through IF/ID/EX/MEM/WB and drives the datapath enables that the multicycle version needs. It stalls on a shared instruction/data memory through a ready handshake, and raises a sticky fault on an illegal opcode or a memory timeout. It sits between the instruction register (Op/Funct), the ALU Zero flag, the memory port and the datapath muxes/enables.

## Interface
- MEM_TIMEOUT, 15: maximum consecutive wait cycles allowed in IF or MEM with MemRdy low before a fault; legal range 1–255.
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous active-low reset
- Op  in  6  opcode from IR; stable from ID through the end of the instruction
- Funct  in  6  funct from IR
- Zero  in  1  ALU zero flag, sampled in EX
- MemRdy  in  1  memory completes the current access this cycle
- MemRead  out  1  memory read request (instruction fetch or lw)
- MemWrite  out  1  memory write request (sw)
- IRWrite  out  1  load the IR with memory read data
- PCWrite  out  1  load the PC from NPC
- RegWrite  out  1  register-file write
- EXTOp  out  1  1 = sign-extend imm16 (addi/lw/sw)
- ALUOp  out  3  000 NOP, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 SLT, 110 SLTU, 111 SLL
- NPCOp  out  2  00 PC+4, 01 branch, 10 jump
- ALUSrcA  out  2  00 rs, 01 shamt, 10 lui immediate
- ALUSrcB  out  1  1 = immediate
- GPRSel  out  1  1 = write rt, 0 = write rd
- WDSel  out  1  1 = write memory data, 0 = write ALU result
- State  out  3  current state, for debug
- Fault  out  1  sticky; high in HALT
- InstrCnt  out  32  retired-instruction count; wraps modulo 2^32

## Operation
- **States:** IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5. Encodings 6 and 7 go to HALT on the next edge.
- **Supported instructions:**
  - R-type (Op=0): add 0x20, addu 0x21, sub 0x22, subu 0x23, and 0x24, or 0x25, slt 0x2A, sltu 0x2B, sll 0x00.
  - I/J-type: addi 0x08, ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else is illegal.
- **IF:** MemRead=1.
  - MemRdy=1: IRWrite=1, go to ID.
  - MemRdy=0: stay in IF; the wait counter increments.
- **ID:** decode only.
  - Illegal instruction: go to HALT.
  - j: PCWrite=1, NPCOp=10, go to IF.
  - Otherwise: go to EX.
- **EX:** ALU controls are active.
  - beq: PCWrite=1, NPCOp = Zero ? 01 : 00, go to IF.
  - lw/sw: go to MEM.
  - All others: go to WB.
- **MEM:**
  - lw: MemRead=1. On MemRdy, go to WB.
  - sw: MemWrite=1. On MemRdy, PCWrite=1, NPCOp=00, go to IF.
  - MemRdy=0: stay in MEM; the wait counter increments.
- **WB:** RegWrite=1, PCWrite=1, NPCOp=00, go to IF.
- **HALT:** absorbing until reset. Fault=1; all strobes 0.
- **Decoded datapath controls** (EXTOp, ALUOp, ALUSrcA/B, GPRSel, WDSel):
  - Driven from Op/Funct in ID, EX, MEM and WB; 0 in IF and HALT.
  - ALUOp mapping:
    - ADD: add, addu, addi, lw, sw, lui.
    - SUB: sub, subu, beq.
    - OR: or, ori.
    - Other R-type ops map to their own codes.
  - ALUSrcA=01 for sll and 10 for lui.
  - ALUSrcB=1 for addi, ori, lw, sw.
  - GPRSel=1 for addi, ori, lui, lw.
  - WDSel=1 for lw only.
- **Wait counter:**
  - Clears on entry to IF or MEM and whenever MemRdy=1.
  - When the counter equals MEM_TIMEOUT with MemRdy still 0, go to HALT.
- **InstrCnt:** increments on every cycle with PCWrite=1.

## Timing
- State, Fault, InstrCnt and the wait counter are registered. All other outputs are combinational from state, Op, Funct, Zero and MemRdy.
- **Reset:** while rstn=0, State=IF, Fault=0, InstrCnt=0, counter=0. Every combinational output is gated to 0, so MemRead=0 during reset. Reset takes effect asynchronously, including mid-instruction and in HALT.
- **Latency with MemRdy always 1:** j 2 cycles, beq 3, R-type/I-ALU 4, sw 4, lw 5. Each wait cycle adds 1.
- **Handshake:** the request is held until the MemRdy cycle inclusive. MemRdy outside IF/MEM is ignored.
- **Simultaneous events:**
  - MemRdy=1 on the cycle the counter reaches MEM_TIMEOUT completes the access; no fault.
  - PCWrite and RegWrite may assert in the same cycle (WB); both are exactly one-cycle pulses.
- Op/Funct changes outside ID–WB have no effect.

## Test plan
- **add, MemRdy tied 1, Funct=0x20:** States IF,ID,EX,WB. ALUOp=001 in EX. Single-cycle RegWrite and PCWrite pulses in WB with GPRSel=0 and NPCOp=00. InstrCnt goes 0→1.
- **lw with MemRdy low for 3 cycles in MEM:** MemRead held 4 cycles. WB follows, with WDSel=1, GPRSel=1, EXTOp=1. Total 8 cycles.
- **beq:** Zero=1 gives NPCOp=01 with PCWrite in EX. Zero=0 gives NPCOp=00. Each takes 3 cycles. j: PCWrite with NPCOp=10 in ID, 2 cycles.
- **Timeout:** MemRdy held 0 in IF with MEM_TIMEOUT=15. HALT and Fault=1 follow after the counter reaches 15, and all strobes stay 0 thereafter. Repeat with MemRdy=1 exactly on the limit cycle: no fault.
- **Illegal Op=0x3F:** HALT from ID; InstrCnt unchanged.
- **Reset mid-operation:** assert rstn=0 mid-MEM of sw. MemWrite drops immediately; State=0 and InstrCnt=0. After release, fetch restarts with MemRead=1.
